// File: rtl/uart_rx_fifo.sv
// Receive-side byte FIFO behind a UART receiver: circular buffer with registered reads,
// occupancy flags and sticky overflow/framing-error flags. Optional macro UART_RX_DROP_BAD_FRAME_EN.
module uart_rx_fifo #(
  parameter int DATA_W = 8,
  parameter int DEPTH  = 16,
  parameter int ADDR_W = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [DATA_W-1:0] rx_data,
  input  logic              rx_valid,
  input  logic              rx_stop_err,
  input  logic              rd_en,
  output logic [DATA_W-1:0] rd_data,
  output logic              rd_valid,
  output logic              empty,
  output logic              full,
  output logic [ADDR_W:0]   count,
  output logic              overflow,
  output logic              frame_err,
  input  logic              err_clr
);

  logic [DATA_W-1:0] mem [DEPTH];

  logic [ADDR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [ADDR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [ADDR_W:0]   count_q, count_d;
  logic              empty_q, empty_d;
  logic              full_q, full_d;
  logic [DATA_W-1:0] rd_data_q, rd_data_d;
  logic              rd_valid_q, rd_valid_d;
  logic              overflow_q, overflow_d;
  logic              frame_err_q, frame_err_d;

  logic accept;
  logic do_push;
  logic do_pop;
  logic drop;
  logic bad_frame;

  assign bad_frame = rx_valid & rx_stop_err;

`ifdef UART_RX_DROP_BAD_FRAME_EN
  assign accept = rx_valid & ~rx_stop_err;
`else
  assign accept = rx_valid;
`endif

  // A full FIFO still accepts a byte when a read frees a slot in the same cycle.
  assign do_pop  = rd_en & ~empty_q;
  assign do_push = accept & (~full_q | rd_en);
  assign drop    = accept & full_q & ~rd_en;

  always_comb begin
    wr_ptr_d    = wr_ptr_q;
    rd_ptr_d    = rd_ptr_q;
    count_d     = count_q;
    rd_data_d   = rd_data_q;
    rd_valid_d  = 1'b0;
    overflow_d  = overflow_q;
    frame_err_d = frame_err_q;

    if (do_push) wr_ptr_d = wr_ptr_q + 1'b1;
    if (do_pop) begin
      rd_ptr_d   = rd_ptr_q + 1'b1;
      rd_data_d  = mem[rd_ptr_q];
      rd_valid_d = 1'b1;
    end

    case ({do_push, do_pop})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase

    // Clear first so a same-cycle set event takes priority.
    if (err_clr) begin
      overflow_d  = 1'b0;
      frame_err_d = 1'b0;
    end
    if (drop)      overflow_d  = 1'b1;
    if (bad_frame) frame_err_d = 1'b1;

    empty_d = (count_d == '0);
    full_d  = (count_d == (ADDR_W+1)'(DEPTH));
  end

  // NOTE: state flops use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      count_q     <= '0;
      empty_q     <= 1'b1;
      full_q      <= 1'b0;
      rd_data_q   <= '0;
      rd_valid_q  <= 1'b0;
      overflow_q  <= 1'b0;
      frame_err_q <= 1'b0;
    end else begin
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      count_q     <= count_d;
      empty_q     <= empty_d;
      full_q      <= full_d;
      rd_data_q   <= rd_data_d;
      rd_valid_q  <= rd_valid_d;
      overflow_q  <= overflow_d;
      frame_err_q <= frame_err_d;
    end
  end

  // NOTE: storage is left unreset; pointers and count alone define which entries are valid.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr_q] <= rx_data;
  end

  assign rd_data   = rd_data_q;
  assign rd_valid  = rd_valid_q;
  assign empty     = empty_q;
  assign full      = full_q;
  assign count     = count_q;
  assign overflow  = overflow_q;
  assign frame_err = frame_err_q;

endmodule

// File: tb/tb_uart_rx_fifo.sv
// Directed self-checking bench for uart_rx_fifo; honours UART_RX_DROP_BAD_FRAME_EN.
module tb_uart_rx_fifo;

  localparam int DATA_W = 8;
  localparam int DEPTH  = 16;
  localparam int ADDR_W = 4;

  logic              clk = 1'b0;
  logic              rst;
  logic [DATA_W-1:0] rx_data;
  logic              rx_valid;
  logic              rx_stop_err;
  logic              rd_en;
  logic [DATA_W-1:0] rd_data;
  logic              rd_valid;
  logic              empty;
  logic              full;
  logic [ADDR_W:0]   count;
  logic              overflow;
  logic              frame_err;
  logic              err_clr;

  int n_checks = 0;
  int n_fail   = 0;

  uart_rx_fifo #(.DATA_W(DATA_W), .DEPTH(DEPTH), .ADDR_W(ADDR_W)) dut (
    .clk(clk), .rst(rst), .rx_data(rx_data), .rx_valid(rx_valid),
    .rx_stop_err(rx_stop_err), .rd_en(rd_en), .rd_data(rd_data),
    .rd_valid(rd_valid), .empty(empty), .full(full), .count(count),
    .overflow(overflow), .frame_err(frame_err), .err_clr(err_clr)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Inputs change and outputs are sampled 1 time unit after each rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input logic [7:0] b, input logic err);
    rx_data = b; rx_stop_err = err; rx_valid = 1'b1;
    tick();
    rx_valid = 1'b0; rx_stop_err = 1'b0;
  endtask

  task automatic pop_expect(input string tag, input logic [7:0] exp);
    rd_en = 1'b1;
    tick();
    rd_en = 1'b0;
    check({tag, "_valid"}, 32'(rd_valid), 32'd1);
    check({tag, "_data"}, 32'(rd_data), 32'(exp));
  endtask

  initial begin
    rst = 1'b0; rx_data = '0; rx_valid = 1'b0; rx_stop_err = 1'b0;
    rd_en = 1'b0; err_clr = 1'b0;
    tick(); tick();
    check("rst_count", 32'(count), 32'd0);
    check("rst_empty", 32'(empty), 32'd1);
    check("rst_full", 32'(full), 32'd0);
    check("rst_rd_data", 32'(rd_data), 32'd0);
    check("rst_rd_valid", 32'(rd_valid), 32'd0);
    check("rst_flags", 32'({overflow, frame_err}), 32'd0);
    rst = 1'b1;
    tick();

    // Single byte round trip with one-cycle read latency
    push(8'd12, 1'b0);
    check("single_count", 32'(count), 32'd1);
    check("single_empty", 32'(empty), 32'd0);
    pop_expect("single_pop", 8'd12);
    check("single_count0", 32'(count), 32'd0);
    check("single_empty1", 32'(empty), 32'd1);
    tick();
    check("rd_valid_one_cycle", 32'(rd_valid), 32'd0);

    // Fill, overflow, clear, drain in order
    for (int i = 1; i <= DEPTH; i++) push(8'(i), 1'b0);
    check("fill_full", 32'(full), 32'd1);
    check("fill_count", 32'(count), 32'd16);
    push(8'hAA, 1'b0);
    check("ovf_count", 32'(count), 32'd16);
    check("ovf_flag", 32'(overflow), 32'd1);
    err_clr = 1'b1; tick(); err_clr = 1'b0;
    check("ovf_clr", 32'(overflow), 32'd0);
    for (int i = 1; i <= DEPTH; i++) pop_expect($sformatf("drain%0d", i), 8'(i));
    check("drain_empty", 32'(empty), 32'd1);
    check("drain_count", 32'(count), 32'd0);

    // rd_en while empty: ignored, rd_data holds
    rd_en = 1'b1; tick(); rd_en = 1'b0;
    check("empty_rd_valid", 32'(rd_valid), 32'd0);
    check("empty_rd_hold", 32'(rd_data), 32'h10);

    // Refill across the pointer wrap, then push+pop while full
    for (int i = 0; i < DEPTH; i++) push(8'(8'h20 + i), 1'b0);
    check("refill_full", 32'(full), 32'd1);
    rx_data = 8'h55; rx_valid = 1'b1; rd_en = 1'b1;
    tick();
    rx_valid = 1'b0; rd_en = 1'b0;
    check("full_rw_data", 32'(rd_data), 32'h20);
    check("full_rw_valid", 32'(rd_valid), 32'd1);
    check("full_rw_count", 32'(count), 32'd16);
    check("full_rw_ovf", 32'(overflow), 32'd0);
    for (int i = 1; i < DEPTH; i++) pop_expect($sformatf("wrap%0d", i), 8'(8'h20 + i));
    pop_expect("wrap_last", 8'h55);
    check("wrap_empty", 32'(empty), 32'd1);

    // Push+pop while empty: only the push happens
    rx_data = 8'h33; rx_valid = 1'b1; rd_en = 1'b1;
    tick();
    rx_valid = 1'b0; rd_en = 1'b0;
    check("empty_rw_valid", 32'(rd_valid), 32'd0);
    check("empty_rw_count", 32'(count), 32'd1);
    pop_expect("empty_rw_pop", 8'h33);

    // Framing error
    push(8'h7E, 1'b1);
    check("ferr_flag", 32'(frame_err), 32'd1);
`ifdef UART_RX_DROP_BAD_FRAME_EN
    check("ferr_count", 32'(count), 32'd0);
    check("ferr_empty", 32'(empty), 32'd1);
`else
    check("ferr_count", 32'(count), 32'd1);
    pop_expect("ferr_pop", 8'h7E);
`endif
    err_clr = 1'b1; tick(); err_clr = 1'b0;
    check("ferr_clr", 32'(frame_err), 32'd0);
    // Set wins over a same-cycle clear
    err_clr = 1'b1; rx_data = 8'h01; rx_stop_err = 1'b1; rx_valid = 1'b1;
    tick();
    err_clr = 1'b0; rx_valid = 1'b0; rx_stop_err = 1'b0;
    check("ferr_set_wins", 32'(frame_err), 32'd1);
    // rx_stop_err without rx_valid is ignored
    err_clr = 1'b1; tick(); err_clr = 1'b0;
    rx_stop_err = 1'b1; tick(); rx_stop_err = 1'b0;
    check("ferr_unqualified", 32'(frame_err), 32'd0);

    // Async reset mid-stream, between clock edges
    for (int i = 0; i < 5; i++) push(8'(8'h90 + i), 1'b0);
    push(8'hEE, 1'b1);
    check("pre_rst_ferr", 32'(frame_err), 32'd1);
    #2 rst = 1'b0;
    #1;
    check("async_count", 32'(count), 32'd0);
    check("async_empty", 32'(empty), 32'd1);
    check("async_flags", 32'({overflow, frame_err}), 32'd0);
    check("async_rd_data", 32'(rd_data), 32'd0);
    tick();
    rst = 1'b1;
    tick();
    push(8'h42, 1'b0);
    check("post_rst_count", 32'(count), 32'd1);
    pop_expect("post_rst_pop", 8'h42);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
